// File: rtl/freq_sweep_pkg.sv
// Shared definitions for the frequency sweep sequencer.
//   SEL_W   : width of the synthesizer frequency-select code
//   mode_t  : sweep pattern codes (up, down, ping-pong, hold)
//   state_t : sequencer state encoding
package freq_sweep_pkg;

   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      MODE_UP       = 2'd0,
      MODE_DOWN     = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_HOLD     = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DWELL = 1'b1
   } state_t;

endpackage

// File: rtl/freq_sweep_ctrl_tick_prescaler.sv
// Free-running prescaler that divides clk down to the dwell tick rate.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, count returns to 0 on the next edge
//   tick  : high while the count sits at TICK_DIV-1 (one cycle per period)
module tick_prescaler #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Not gated by clr: the controller folds its own state into clr, and
   // gating here would close a combinational loop through dwell_end.
   assign tick = (cnt == LAST);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency-select sweep sequencer for the audio synthesizer.
//   clk, rst_n          : clock and asynchronous active-low reset
//   start, abort        : begin a sweep when idle / terminate immediately
//   mode                : 0 up, 1 down, 2 ping-pong, 3 hold
//   lo_sel, hi_sel      : range endpoints, either order
//   dwell               : prescaler ticks per step (0 behaves as 1)
//   continuous          : repeat until abort
//   freq_sel            : code to the synthesizer, 0 = silent
//   busy, step, done    : sweep active / load pulse / completion pulse
//
// state    | meaning
// ST_IDLE  | silent, waiting for start
// ST_DWELL | holding freq_sel, counting dwell*TICK_DIV cycles
module freq_sweep_ctrl
   import freq_sweep_pkg::*;
#(
   parameter int TICK_DIV = 100000,
   parameter int DWELL_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [SEL_W-1:0]   lo_sel,
   input  logic [SEL_W-1:0]   hi_sel,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               continuous,
   output logic [SEL_W-1:0]   freq_sel,
   output logic               busy,
   output logic               step,
   output logic               done
);

   state_t             state;
   mode_t              mode_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dcnt;
   logic               cont_q;
   logic               dir_up;
   logic [SEL_W-1:0]   lo_q;
   logic [SEL_W-1:0]   hi_q;

   logic               tick;
   logic               dwell_end;
   logic               prescale_clr;
   logic [SEL_W-1:0]   next_sel;
   logic               next_dir;
   logic               finish;

   assign dwell_end    = (state == ST_DWELL) && tick && (dcnt == dwell_q - DWELL_W'(1));
   // Prescaler restarts on every load so each code is held a whole number of periods.
   assign prescale_clr = (state == ST_IDLE) || abort || dwell_end;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (prescale_clr),
      .tick  (tick)
   );

   always_comb begin
      next_sel = freq_sel;
      next_dir = dir_up;
      finish   = 1'b0;
      case (mode_q)
         MODE_UP: begin
            if (freq_sel < hi_q)  next_sel = freq_sel + 1'b1;
            else if (cont_q)      next_sel = lo_q;
            else                  finish   = 1'b1;
         end
         MODE_DOWN: begin
            if (freq_sel > lo_q)  next_sel = freq_sel - 1'b1;
            else if (cont_q)      next_sel = hi_q;
            else                  finish   = 1'b1;
         end
         MODE_PINGPONG: begin
            if (lo_q == hi_q) begin
               finish = !cont_q;
            end else if (dir_up) begin
               if (freq_sel < hi_q) begin
                  next_sel = freq_sel + 1'b1;
               end else begin
                  next_dir = 1'b0;
                  next_sel = hi_q - 1'b1;
               end
            end else if (freq_sel > lo_q) begin
               next_sel = freq_sel - 1'b1;
            end else if (cont_q) begin
               next_dir = 1'b1;
               next_sel = lo_q + 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         default: finish = !cont_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_UP;
         dwell_q  <= DWELL_W'(1);
         dcnt     <= '0;
         cont_q   <= 1'b0;
         dir_up   <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
         freq_sel <= '0;
         busy     <= 1'b0;
         step     <= 1'b0;
         done     <= 1'b0;
      end else begin
         step <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               freq_sel <= '0;
               busy     <= 1'b0;
               if (start && !abort) begin
                  mode_q   <= mode_t'(mode);
                  dwell_q  <= (dwell == '0) ? DWELL_W'(1) : dwell;
                  cont_q   <= continuous;
                  lo_q     <= (lo_sel <= hi_sel) ? lo_sel : hi_sel;
                  hi_q     <= (lo_sel <= hi_sel) ? hi_sel : lo_sel;
                  freq_sel <= (mode_t'(mode) == MODE_DOWN) ?
                              ((lo_sel <= hi_sel) ? hi_sel : lo_sel) :
                              ((lo_sel <= hi_sel) ? lo_sel : hi_sel);
                  dir_up   <= 1'b1;
                  dcnt     <= '0;
                  busy     <= 1'b1;
                  step     <= 1'b1;
                  state    <= ST_DWELL;
               end
            end
            ST_DWELL: begin
               if (abort) begin
                  state    <= ST_IDLE;
                  freq_sel <= '0;
                  busy     <= 1'b0;
                  dcnt     <= '0;
               end else if (dwell_end) begin
                  dcnt <= '0;
                  if (finish) begin
                     state    <= ST_IDLE;
                     freq_sel <= '0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     freq_sel <= next_sel;
                     dir_up   <= next_dir;
                     step     <= 1'b1;
                  end
               end else if (tick) begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
module tb_freq_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [3:0] lo_sel = 4'd0;
   logic [3:0] hi_sel = 4'd0;
   logic [7:0] dwell = 8'd0;
   logic       continuous = 1'b0;
   logic [3:0] freq_sel;
   logic       busy;
   logic       step;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;
   int seq [0:15];

   always #5 clk = ~clk;

   freq_sweep_ctrl #(.TICK_DIV(4), .DWELL_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .lo_sel     (lo_sel),
      .hi_sel     (hi_sel),
      .dwell      (dwell),
      .continuous (continuous),
      .freq_sel   (freq_sel),
      .busy       (busy),
      .step       (step),
      .done       (done)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic exp_done);
      check_val({tag, ".sel"},  32'(freq_sel), 32'd0);
      check_val({tag, ".busy"}, 32'(busy),     32'd0);
      check_val({tag, ".step"}, 32'(step),     32'd0);
      check_val({tag, ".done"}, 32'(done),     32'(exp_done));
   endtask

   // Drive config and a one-cycle start pulse; returns at the negedge after
   // the loading edge, then scrambles config to show it is not re-sampled.
   task automatic do_start(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] d, input logic c);
      @(negedge clk);
      mode = m; lo_sel = a; hi_sel = b; dwell = d; continuous = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'd3; lo_sel = 4'd0; hi_sel = 4'd15; dwell = 8'd9; continuous = ~c;
   endtask

   // Checks seq[0..n-1], each held len cycles; first sample is taken at the
   // current negedge. With fin set, also checks the done cycle that follows.
   task automatic sweep_check(input int n, input int len, input bit fin);
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < len; c++) begin
            if (!(i == 0 && c == 0)) @(negedge clk);
            check_val($sformatf("sel[%0d.%0d]", i, c),  32'(freq_sel), 32'(seq[i]));
            check_val($sformatf("busy[%0d.%0d]", i, c), 32'(busy),     32'd1);
            check_val($sformatf("step[%0d.%0d]", i, c), 32'(step),     (c == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("done[%0d.%0d]", i, c), 32'(done),     32'd0);
         end
      end
      if (fin) begin
         @(negedge clk);
         check_idle("finish", 1'b1);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_idle("reset", 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset", 1'b0);

      // 1: up 3..5, dwell 2 -> 8 cycles per code
      do_start(2'd0, 4'd3, 4'd5, 8'd2, 1'b0);
      seq[0] = 3; seq[1] = 4; seq[2] = 5;
      sweep_check(3, 8, 1'b1);
      @(negedge clk);
      check_idle("t1_after", 1'b0);

      // 2: ping-pong 1..3, dwell 1
      do_start(2'd2, 4'd1, 4'd3, 8'd1, 1'b0);
      seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 2; seq[4] = 1;
      sweep_check(5, 4, 1'b1);
      @(negedge clk);
      check_idle("t2_after", 1'b0);

      // 3: down with swapped endpoints, dwell 0 acts as 1
      do_start(2'd1, 4'd9, 4'd7, 8'd0, 1'b0);
      seq[0] = 9; seq[1] = 8; seq[2] = 7;
      sweep_check(3, 4, 1'b1);
      @(negedge clk);
      check_idle("t3_after", 1'b0);

      // 4: continuous up 14..15, start while busy ignored, abort mid-dwell
      do_start(2'd0, 4'd14, 4'd15, 8'd1, 1'b1);
      seq[0] = 14; seq[1] = 15; seq[2] = 14;
      sweep_check(3, 4, 1'b0);
      @(negedge clk);
      check_val("t4_wrap_sel",  32'(freq_sel), 32'd15);
      check_val("t4_wrap_step", 32'(step),     32'd1);
      start = 1'b1;
      @(negedge clk);
      check_val("t4_busy_start_sel",  32'(freq_sel), 32'd15);
      check_val("t4_busy_start_step", 32'(step),     32'd0);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("t4_abort", 1'b0);
      @(negedge clk);
      check_idle("t4_abort_after", 1'b0);

      // 5: continuous hold at 6, then async reset mid-cycle
      do_start(2'd3, 4'd6, 4'd6, 8'd1, 1'b1);
      seq[0] = 6; seq[1] = 6;
      sweep_check(2, 4, 1'b0);
      @(negedge clk);
      check_val("t5_hold_sel",  32'(freq_sel), 32'd6);
      check_val("t5_hold_step", 32'(step),     32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle("t5_async_rst", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // 6: start+abort together in idle, then restart right after done
      @(negedge clk);
      start = 1'b1; abort = 1'b1; mode = 2'd0; lo_sel = 4'd2; hi_sel = 4'd3; dwell = 8'd1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_idle("t6_start_abort", 1'b0);
      do_start(2'd0, 4'd2, 4'd3, 8'd1, 1'b0);
      seq[0] = 2; seq[1] = 3;
      sweep_check(2, 4, 1'b1);
      mode = 2'd0; lo_sel = 4'd5; hi_sel = 4'd5; dwell = 8'd1; continuous = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seq[0] = 5;
      sweep_check(1, 4, 1'b1);
      @(negedge clk);
      check_idle("t6_after", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
